scv_apu_mbox: RTL and testbench
===============================

# scv_apu_mbox

CPU-to-APU sound command mailbox for the Super Cassette Vision core. It sits between the uPD7801 data bus and the uPD1771C port A, and replaces the single-byte write latch with a buffered, acknowledged byte stream. CPU writes decoded by the VDC's SCPUB select are queued in a small FIFO. The APU consumes bytes by pulsing its PB0 acknowledge line. A busy indication is returned to the CPU on INT1.

## Interface
Parameters:
- DEPTH_LOG2, default 2: FIFO depth is 2^DEPTH_LOG2 entries (legal range 1..4).

Ports:
- CLK  in  1  core clock (2 × video XTAL).
- RES  in  1  synchronous, active-high reset.
- CP2_NEGEDGE  in  1  CPU phase-2 falling-edge strobe from clkgen; bus sample point.
- SCPUB  in  1  APU select from VDC address decode, active low.
- WRB  in  1  CPU write strobe, active low.
- DB_I  in  8  CPU data bus.
- APU_RESB  in  1  APU reset (CPU PC3), active low; low flushes the mailbox.
- APU_ACK  in  1  APU PB0; a rising edge means the APU has consumed the presented byte.
- APU_DB  out  8  byte presented to APU PA_I.
- APU_VALID  out  1  high while APU_DB holds an unconsumed queued byte.
- CPU_BUSY  out  1  to CPU INT1; high when the FIFO is full or APU_ACK is high.
- LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy.
- OVF  out  1  sticky overflow flag.

## Operation
- Write qualifier: wq = CP2_NEGEDGE & ~SCPUB & ~WRB.
- Write arming: an internal arm flag is set on any CP2_NEGEDGE where (~SCPUB & ~WRB) is false. A push happens only on a wq cycle with arm set, and that push clears arm. Result: exactly one push per CPU write cycle, however many strobes it spans.
- Push: writes DB_I into mem[wr], then wr increments modulo depth and LEVEL increments.
- Pop: occurs on a rising edge of APU_ACK, detected against a registered copy ack_q, when LEVEL>0.
  - The popped head byte is copied into last_db.
  - rd increments and LEVEL decrements.
  - A rising edge with LEVEL==0 is ignored.
- APU_DB output:
  - LEVEL>0: APU_DB = mem[rd] (combinational head).
  - LEVEL==0: APU_DB = last_db, so the port holds the last byte, matching latch behaviour.
- APU_VALID = (LEVEL != 0).
- Simultaneous push and pop:
  - LEVEL>0, including full: both execute, LEVEL unchanged, no overflow.
  - LEVEL==0: only the push executes. The pop is discarded and last_db is unchanged.
- Overflow: a push attempt with LEVEL==depth and no simultaneous pop drops the byte and sets OVF. Only RES clears OVF.
- Flush (APU_RESB low, sampled every CLK):
  - wr, rd and LEVEL are cleared, last_db is cleared to 0, and arm is set.
  - Pushes and pops are suppressed while APU_RESB is low.
  - OVF is preserved.
- CPU_BUSY = (LEVEL==depth) | APU_ACK, combinational.

## Timing
- All state updates on posedge CLK.
- Reset values (RES high): wr=rd=0, LEVEL=0, last_db=8'h00, arm=1, ack_q=0, OVF=0. Resulting outputs: APU_DB=8'h00, APU_VALID=0, CPU_BUSY=APU_ACK.
- RES has priority over flush. Flush has priority over push and pop.
- Push latency: data accepted at edge N is visible on APU_DB and APU_VALID after edge N when LEVEL was 0 before the push (0-cycle head, combinational read of the registered mem).
- Pop latency: APU_ACK rises before edge N and is sampled at N (ack_q was 0). The next head, or last_db, is shown after edge N.
- APU_ACK held high for multiple cycles gives a single pop. It must return low (ack_q=0) before another pop can occur.
- Pointer wrap: wr and rd are DEPTH_LOG2 bits and wrap naturally. LEVEL is DEPTH_LOG2+1 bits so that full and empty are distinct.
- RES or flush asserted mid-write-cycle: arm=1 afterward, so a still-low WRB at the next qualifying strobe pushes once. Benches must drive WRB high in between if no push is intended.

## Test plan
- Reset, then one write: RES 1 cycle; WRB/SCPUB low for 3 consecutive CP2_NEGEDGE with DB_I=8'h5A -> LEVEL=1, APU_DB=8'h5A, APU_VALID=1, exactly one push.
- Ack drain: queue 8'h11, 8'h22; pulse APU_ACK high for 4 cycles, low, high again -> APU_DB 8'h11→8'h22→8'h22 (held), LEVEL 2→1→0, APU_VALID falls after second pop, CPU_BUSY high while ACK high.
- Fill and overflow, DEPTH_LOG2=2: five separate writes 8'h01..8'h05 without ack -> LEVEL=4, CPU_BUSY=1, OVF=1, pops yield 8'h01..8'h04 only.
- Simultaneous push and pop at full: FIFO holds 01..04; write 8'hAA on the same edge an ACK rising edge is sampled -> LEVEL stays 4, OVF stays 0, subsequent pops give 02,03,04,AA.
- Wrap-around: 10 write/ack pairs with data 8'h80+i -> each byte is observed in order on APU_DB, pointers wrap twice, LEVEL never exceeds 1.
- Flush: queue 3 bytes with OVF=1, drive APU_RESB low 2 cycles -> LEVEL=0, APU_DB=8'h00, APU_VALID=0, OVF still 1. A write during the low period is ignored. A write after APU_RESB returns high is accepted.

Source files
------------

// File: rtl/scv_apu_mbox.sv
// CPU-to-APU sound command mailbox: buffers uPD7801 writes to the uPD1771C port A
// as a small FIFO. Each byte is consumed by a rising edge on the APU's PB0 acknowledge.
module scv_apu_mbox #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  CP2_NEGEDGE,
    input  logic                  SCPUB,
    input  logic                  WRB,
    input  logic [7:0]            DB_I,
    input  logic                  APU_RESB,
    input  logic                  APU_ACK,
    output logic [7:0]            APU_DB,
    output logic                  APU_VALID,
    output logic                  CPU_BUSY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVF
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr;
    logic [DEPTH_LOG2-1:0] rd;
    logic [7:0]            last_db;
    logic                  arm;
    logic                  ack_q;

    logic bus_sel;
    logic push_try;
    logic ack_rise;
    logic full;
    logic empty;
    logic run;
    logic push;
    logic pop;
    logic ovf_set;

    // Handshake: APU_VALID high means APU_DB holds an unconsumed byte; the APU
    // consumes it with a rising edge on APU_ACK. Edges while empty are ignored.
    always_comb begin
        bus_sel  = ~SCPUB & ~WRB;
        push_try = CP2_NEGEDGE & bus_sel & arm;
        ack_rise = APU_ACK & ~ack_q;
        full     = (LEVEL == DEPTH_L);
        empty    = (LEVEL == '0);
        run      = ~RES & APU_RESB;
        pop      = run & ack_rise & ~empty;
        push     = run & push_try & (~full | pop);
        ovf_set  = run & push_try & full & ~pop;
    end

    // Empty port keeps showing the last consumed byte, like the old write latch.
    assign APU_DB    = empty ? last_db : mem[rd];
    assign APU_VALID = ~empty;
    assign CPU_BUSY  = full | APU_ACK;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr] <= DB_I;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            wr      <= '0;
            rd      <= '0;
            LEVEL   <= '0;
            last_db <= 8'h00;
            arm     <= 1'b1;
            ack_q   <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            ack_q <= APU_ACK;
            if (!APU_RESB) begin
                // Flush keeps OVF so the CPU can still see a lost command.
                wr      <= '0;
                rd      <= '0;
                LEVEL   <= '0;
                last_db <= 8'h00;
                arm     <= 1'b1;
            end else begin
                // One push per bus write cycle: re-arm only on a strobe outside a write.
                if (push_try) begin
                    arm <= 1'b0;
                end else if (CP2_NEGEDGE && !bus_sel) begin
                    arm <= 1'b1;
                end
                if (push) begin
                    wr <= wr + 1'b1;
                end
                if (pop) begin
                    rd      <= rd + 1'b1;
                    last_db <= mem[rd];
                end
                if (push && !pop) begin
                    LEVEL <= LEVEL + 1'b1;
                end else if (pop && !push) begin
                    LEVEL <= LEVEL - 1'b1;
                end
                if (ovf_set) begin
                    OVF <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scv_apu_mbox.sv
// Bench for scv_apu_mbox: directed scenarios then random traffic, all checked
// against a queue model of the mailbox.
module tb_scv_apu_mbox;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                RES         = 1'b1;
    logic                CP2_NEGEDGE = 1'b0;
    logic                SCPUB       = 1'b1;
    logic                WRB         = 1'b1;
    logic [7:0]          DB_I        = 8'h00;
    logic                APU_RESB    = 1'b1;
    logic                APU_ACK     = 1'b0;
    logic [7:0]          APU_DB;
    logic                APU_VALID;
    logic                CPU_BUSY;
    logic [DEPTH_LOG2:0] LEVEL;
    logic                OVF;

    scv_apu_mbox #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .CLK(CLK), .RES(RES), .CP2_NEGEDGE(CP2_NEGEDGE), .SCPUB(SCPUB), .WRB(WRB),
        .DB_I(DB_I), .APU_RESB(APU_RESB), .APU_ACK(APU_ACK), .APU_DB(APU_DB),
        .APU_VALID(APU_VALID), .CPU_BUSY(CPU_BUSY), .LEVEL(LEVEL), .OVF(OVF)
    );

    // reference model and scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] last_m;
    logic       ovf_m;
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] db;
        db = (exp_q.size() != 0) ? exp_q[0] : last_m;
        check({tag, " db"},    32'(APU_DB),    32'(db));
        check({tag, " valid"}, 32'(APU_VALID), 32'(exp_q.size() != 0));
        check({tag, " level"}, 32'(LEVEL),     32'(exp_q.size()));
        check({tag, " ovf"},   32'(OVF),       32'(ovf_m));
        check({tag, " busy"},  32'(CPU_BUSY),  32'((exp_q.size() == DEPTH) || APU_ACK));
    endtask

    function automatic void model_push(input logic [7:0] d);
        if (exp_q.size() == DEPTH) ovf_m = 1'b1;
        else exp_q.push_back(d);
    endfunction

    function automatic void model_pop();
        if (exp_q.size() != 0) last_m = exp_q.pop_front();
    endfunction

    // driver tasks
    task automatic do_reset();
        RES = 1'b1; CP2_NEGEDGE = 1'b0; SCPUB = 1'b1; WRB = 1'b1;
        APU_RESB = 1'b1; APU_ACK = 1'b0;
        tick();
        RES = 1'b0;
        exp_q.delete();
        last_m = 8'h00;
        ovf_m  = 1'b0;
        check_all("reset");
    endtask

    // idle strobe outside a write cycle, which re-arms the write detector
    task automatic idle_strobe();
        SCPUB = 1'b1; WRB = 1'b1; CP2_NEGEDGE = 1'b1;
        tick();
        CP2_NEGEDGE = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input logic [7:0] d, input int strobes);
        SCPUB = 1'b0; WRB = 1'b0; DB_I = d;
        for (int s = 0; s < strobes; s++) begin
            CP2_NEGEDGE = 1'b1;
            tick();
            if (s == 0) model_push(d);
            check_all("wr_strobe");
            CP2_NEGEDGE = 1'b0;
            tick();
        end
        idle_strobe();
        check_all("wr_done");
    endtask

    task automatic ack_pulse(input int hold);
        APU_ACK = 1'b1;
        tick();
        model_pop();
        check_all("ack_edge");
        for (int h = 1; h < hold; h++) begin
            tick();
            check_all("ack_hold");
        end
        APU_ACK = 1'b0;
        tick();
        check_all("ack_low");
    endtask

    // write strobe on the same edge as an ACK rising edge
    task automatic write_with_ack(input logic [7:0] d);
        SCPUB = 1'b0; WRB = 1'b0; DB_I = d; CP2_NEGEDGE = 1'b1; APU_ACK = 1'b1;
        tick();
        if (exp_q.size() != 0) model_pop();
        model_push(d);
        check_all("wa_edge");
        CP2_NEGEDGE = 1'b0; APU_ACK = 1'b0;
        tick();
        idle_strobe();
        check_all("wa_done");
    endtask

    // APU reset low for two edges, with a write strobe attempted during it
    task automatic flush_mbox();
        APU_RESB = 1'b0;
        SCPUB = 1'b0; WRB = 1'b0; DB_I = 8'h77; CP2_NEGEDGE = 1'b1;
        tick();
        exp_q.delete();
        last_m = 8'h00;
        check_all("flush_1");
        CP2_NEGEDGE = 1'b0; SCPUB = 1'b1; WRB = 1'b1;
        tick();
        check_all("flush_2");
        APU_RESB = 1'b1;
        tick();
        check_all("flush_rel");
    endtask

    initial begin
        int r;

        // reset, one write spanning three strobes
        do_reset();
        cpu_write(8'h5A, 3);
        check("one_push level", 32'(LEVEL), 32'd1);
        check("one_push db", 32'(APU_DB), 32'h5A);

        // ack drain: held ACK pops once, second rise pops again, port holds last byte
        do_reset();
        cpu_write(8'h11, 1);
        cpu_write(8'h22, 1);
        check("drain head", 32'(APU_DB), 32'h11);
        ack_pulse(4);
        check("drain second", 32'(APU_DB), 32'h22);
        ack_pulse(1);
        check("drain held", 32'(APU_DB), 32'h22);
        check("drain valid", 32'(APU_VALID), 32'd0);

        // fill and overflow
        do_reset();
        for (int i = 1; i <= 5; i++) cpu_write(8'(i), 1);
        check("fill ovf", 32'(OVF), 32'd1);
        check("fill busy", 32'(CPU_BUSY), 32'd1);
        for (int i = 1; i <= 4; i++) ack_pulse(1);
        check("fill last", 32'(APU_DB), 32'h04);

        // simultaneous push and pop while full
        do_reset();
        for (int i = 1; i <= 4; i++) cpu_write(8'(i), 1);
        write_with_ack(8'hAA);
        check("simul level", 32'(LEVEL), 32'd4);
        check("simul ovf", 32'(OVF), 32'd0);
        for (int i = 0; i < 4; i++) ack_pulse(2);
        check("simul tail", 32'(APU_DB), 32'hAA);

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            cpu_write(8'h80 + 8'(i), 1);
            ack_pulse(1);
        end

        // flush with OVF set
        do_reset();
        for (int i = 1; i <= 5; i++) cpu_write(8'h30 + 8'(i), 1);
        ack_pulse(1);
        flush_mbox();
        check("flush ovf kept", 32'(OVF), 32'd1);
        cpu_write(8'hC3, 1);
        check("post flush db", 32'(APU_DB), 32'hC3);

        // random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8) cpu_write(8'($urandom_range(0, 255)), $urandom_range(1, 3));
            else if (r < 14) ack_pulse($urandom_range(1, 3));
            else if (r < 19) write_with_ack(8'($urandom_range(0, 255)));
            else flush_mbox();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
